// File: rtl/pb_one_pulse.sv
// Pushbutton conditioner: two-flop synchronizer, debounce FSM, one-cycle
// press strobe with optional auto-repeat, debounced level and a wrapping
// press counter. All outputs come straight from flops.
module pb_one_pulse #(
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_in,
    output logic       pulse_out,
    output logic       pb_level,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [7:0]  DB_LAST   = 8'(DB_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [7:0]  db_cnt_q, db_cnt_d;
    logic [15:0] hold_q, hold_d;
    logic        rep_phase_q, rep_phase_d;   // 0: waiting for first repeat, 1: in repeat cadence
    logic        pulse_q, pulse_d;
    logic        level_q, level_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        pb_sync;
    logic        press_fire_s;
    logic        stay_pressed_s;
    logic        rep_fire_s;
    logic [15:0] rep_target_s;

    assign pb_sync   = sync2_q;
    assign pulse_out = pulse_q;
    assign pb_level  = level_q;
    assign press_cnt = cnt_q;

    // State register plus synchronizer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            db_cnt_q    <= 8'd0;
            hold_q      <= 16'd0;
            rep_phase_q <= 1'b0;
            pulse_q     <= 1'b0;
            level_q     <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            sync1_q     <= pb_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_q      <= hold_d;
            rep_phase_q <= rep_phase_d;
            pulse_q     <= pulse_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic: debounce the synchronized level in both directions.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        case (state_q)
            IDLE: begin
                if (pb_sync) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = 8'd1;
                end else begin
                    db_cnt_d = 8'd0;
                end
            end
            PRESS_WAIT: begin
                if (!pb_sync) begin
                    state_d  = IDLE;
                    db_cnt_d = 8'd0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = PRESSED;
                    db_cnt_d = 8'd0;
                end else begin
                    db_cnt_d = db_cnt_q + 8'd1;
                end
            end
            PRESSED: begin
                if (!pb_sync) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = 8'd1;
                end else begin
                    db_cnt_d = 8'd0;
                end
            end
            RELEASE_WAIT: begin
                if (pb_sync) begin
                    state_d  = PRESSED;
                    db_cnt_d = 8'd0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = IDLE;
                    db_cnt_d = 8'd0;
                end else begin
                    db_cnt_d = db_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = 8'd0;
            end
        endcase
    end

    // Output logic: press strobe, auto-repeat timing, level and press count.
    always_comb begin
        press_fire_s   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        // A repeat may only be scheduled when the next cycle is still PRESSED.
        stay_pressed_s = (state_q == PRESSED) && pb_sync;
        rep_target_s   = rep_phase_q ? REP_LAST : HOLD_LAST;
        rep_fire_s     = REPEAT_EN && stay_pressed_s && (hold_q == rep_target_s);

        hold_d      = hold_q;
        rep_phase_d = rep_phase_q;
        if (press_fire_s) begin
            hold_d      = 16'd0;
            rep_phase_d = 1'b0;
        end else if (rep_fire_s) begin
            hold_d      = 16'd0;
            rep_phase_d = 1'b1;
        end else if (REPEAT_EN && stay_pressed_s) begin
            hold_d      = hold_q + 16'd1;
        end else begin
            hold_d      = hold_q;
        end

        pulse_d = press_fire_s || rep_fire_s;
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        if (press_fire_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

endmodule

// File: tb/tb_pb_one_pulse.sv
// Bench for pb_one_pulse: two instances (auto-repeat off / on) driven by the
// same button, compared every cycle against a run-length debounce model, plus
// directed scenarios with hand-computed expectations.
module tb_pb_one_pulse;

    localparam int DB   = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pb  = 1'b0;
    logic       p0, l0, p1, l1;
    logic [7:0] c0, c1;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    // Model state per instance: synchronizer delay line, debounced level,
    // length of the current run of disagreeing samples, held cycles, outputs.
    bit m_s1    [2];
    bit m_s2    [2];
    bit m_level [2];
    int m_run   [2];
    int m_h     [2];
    bit m_pulse [2];
    int m_cnt   [2];

    always #5 clk = ~clk;

    pb_one_pulse #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) u0 (
        .clk(clk), .rst(rst), .pb_in(pb), .pulse_out(p0), .pb_level(l0), .press_cnt(c0));
    pb_one_pulse #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) u1 (
        .clk(clk), .rst(rst), .pb_in(pb), .pulse_out(p1), .pb_level(l1), .press_cnt(c1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit en);
        bit s;
        s = m_s2[i];
        if (rst) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_level[i] = 1'b0;
            m_run[i] = 0; m_h[i] = 0; m_pulse[i] = 1'b0; m_cnt[i] = 0;
        end else begin
            m_pulse[i] = 1'b0;
            if (s != m_level[i]) begin
                // PRESSED-with-low-sample does not count as a held cycle
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_level[i] = s;
                    m_run[i]   = 0;
                    if (s) begin
                        m_pulse[i] = 1'b1;
                        m_cnt[i]   = (m_cnt[i] + 1) % 256;
                        m_h[i]     = 0;
                    end
                end
            end else begin
                if (m_level[i] && m_run[i] == 0) begin
                    m_h[i]++;
                    if (en && (m_h[i] == HOLD || (m_h[i] > HOLD && (m_h[i] - HOLD) % REP == 0)))
                        m_pulse[i] = 1'b1;
                end
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = pb;
        end
    endtask

    // Advance the reference model on every rising edge.
    always @(posedge clk) begin
        model_step(0, 1'b0);
        model_step(1, 1'b1);
    end

    // Compare both instances against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("m_pulse0", p0, m_pulse[0]);
            chk("m_level0", l0, m_level[0]);
            chk("m_cnt0",   c0, m_cnt[0]);
            chk("m_pulse1", p1, m_pulse[1]);
            chk("m_level1", l1, m_level[1]);
            chk("m_cnt1",   c1, m_cnt[1]);
        end
    end

    task automatic step(input bit r, input bit p);
        rst = r;
        pb  = p;
        @(posedge clk);
        #1;
    endtask

    int     npulse;
    int     base;
    int     dur;
    bit     lvl;

    initial begin
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        started = 1'b1;
        step(1'b1, 1'b0);
        chk("rst_pulse", p0, 0);
        chk("rst_level", l0, 0);
        chk("rst_cnt",   c0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Bounce: 3 high samples then 10 low -> nothing accepted.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            chk("bounce_pulse", p0, 0);
            chk("bounce_level", l0, 0);
        end
        chk("bounce_cnt", c0, 0);

        // Press latency: first high sample at step 1, pulse in the cycle after step DB+2.
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1);
            chk("lat_pulse", p0, (i == DB + 2));
            chk("lat_level", l0, (i >= DB + 2));
        end
        chk("lat_cnt", c0, 1);

        // Release bounce: 2 low, 1 high, 10 low -> no extra pulse, level ends low.
        base = c0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            chk("relb_pulse", p0, 0);
        end
        chk("relb_level", l0, 0);
        chk("relb_cnt", c0, base);

        // Auto-repeat: held 40 cycles after the press pulse.
        step(1'b1, 1'b0);
        for (int i = 1; i <= DB + 2; i++) step(1'b0, 1'b1);
        chk("rep_first", p1, 1);
        for (int off = 1; off <= 41; off++) begin
            step(1'b0, 1'b1);
            chk("rep_off", p1, (off == 16 || off == 24 || off == 32 || off == 40));
            chk("rep_off_noen", p0, 0);
        end
        chk("rep_cnt", c1, 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // Reset during PRESS_WAIT on the edge a pulse would have been registered.
        step(1'b1, 1'b0);
        for (int i = 1; i <= DB + 1; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("rstpri_pulse", p0, 0);
        chk("rstpri_cnt", c0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1);
            chk("rstrel_pulse", p0, (i == DB + 2));
        end
        chk("rstrel_cnt", c0, 1);

        // Wrap: 256 clean presses from reset.
        step(1'b1, 1'b0);
        npulse = 0;
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 7; i++) begin
                step(1'b0, 1'b1);
                if (p0) npulse++;
            end
            for (int i = 0; i < 7; i++) begin
                step(1'b0, 1'b0);
                if (p0) npulse++;
            end
        end
        chk("wrap_cnt", c0, 0);
        chk("wrap_pulses", npulse, 256);

        // Randomized bursts: short bounces, long holds, occasional reset.
        step(1'b1, 1'b0);
        for (int b = 0; b < 300; b++) begin
            lvl = 1'($urandom_range(0, 1));
            dur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70)) : int'($urandom_range(1, 6));
            for (int i = 0; i < dur; i++)
                step(($urandom_range(0, 299) == 0), lvl);
        end

        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
